// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the inverse AddRoundKey/MixColumns stage.
// Used by inv_mixcol_column and inv_addkey_mixcol.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = xtime(a);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(a));
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mixcol_column.sv
// Combinational InvMixColumns on one state column; byte index 0..3 is the row.
module inv_mixcol_column
  import aes_pkg::*;
(
  input  logic [3:0][7:0] col_in,
  output logic [3:0][7:0] col_out
);

  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      col_out[r] = gf_mul14(col_in[2'(r)])     ^ gf_mul11(col_in[2'(r + 1)]) ^
                   gf_mul13(col_in[2'(r + 2)]) ^ gf_mul9(col_in[2'(r + 3)]);
    end
  end

endmodule

// File: rtl/inv_addkey_mixcol.sv
// Decryption round stage: AddRoundKey on accept, then InvMixColumns one column per cycle.
// Define INV_ADDKEY_MIXCOL_BYPASS_EN to add last_round, which skips the mixing for the final round.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// BUSY  | mixing column col_cnt of the work register into the output register
// DONE  | result held on out_state with out_valid=1 until out_ready
module inv_addkey_mixcol
  import aes_pkg::*;
#(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  in_state,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  in_key,
`ifdef INV_ADDKEY_MIXCOL_BYPASS_EN
  input  logic                                  last_round,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  out_state,
  output logic                                  busy
);

  if (NO_ROWS != 4 || NO_COLS != 4) begin : g_bad_dims
    $error("inv_addkey_mixcol: NO_ROWS and NO_COLS must both be 4");
  end

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]      state_q, state_d;
  logic [1:0]      col_cnt_q, col_cnt_d;
  state_t          work_q, work_d;
  state_t          out_q, out_d;
  logic [3:0][7:0] col_sel;
  logic [3:0][7:0] col_mix;

  always_comb begin
    col_sel = '0;
    for (int r = 0; r < 4; r++) col_sel[r] = work_q[r][col_cnt_q];
  end

  inv_mixcol_column u_col (
    .col_in  (col_sel),
    .col_out (col_mix)
  );

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    out_d     = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d    = in_state ^ in_key;
          col_cnt_d = 2'd0;
          state_d   = ST_BUSY;
`ifdef INV_ADDKEY_MIXCOL_BYPASS_EN
          // Final round has no InvMixColumns: publish the keyed state directly.
          if (last_round) begin
            out_d   = in_state ^ in_key;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_BUSY: begin
        for (int r = 0; r < 4; r++) out_d[r][col_cnt_q] = col_mix[r];
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
      out_q     <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign out_state = out_q;

endmodule
